tx_sym_source: RTL and testbench

4-ASK symbol source feeding `TX_filt_MF`. Generates 2-bit symbols from an internal PRBS-15 (or a fixed test pattern), Gray-maps them to the four 18-bit 1s17 levels that the filter's level decoder recognises, and holds each symbol for `SPS` clocks. Sits directly upstream of the TX/matched filter; `sym_bits` and `sym_strobe` also feed the BER checker.

---
 rtl/tx_pkg.sv | 44 ++++
 rtl/prbs15_2step.sv | 23 ++
 rtl/tx_sym_source.sv | 86 ++++++++
 tb/tb_tx_sym_source.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared definitions for the 4-ASK transmit symbol path: levels, symbol type,
// mode encodings and PRBS-15 tap positions.
package tx_pkg;

    localparam int LFSR_W = 15;
    localparam int TAP_HI = 14;
    localparam int TAP_LO = 13;
    localparam int PH_W   = 4;

    // -131072 is the most negative 18-bit value; written as a bit pattern
    localparam logic signed [17:0] LVL_M3 = 18'sh20000;
    localparam logic signed [17:0] LVL_M1 = -18'sd43690;
    localparam logic signed [17:0] LVL_P1 = 18'sd43690;
    localparam logic signed [17:0] LVL_P3 = 18'sd131071;

    typedef logic [1:0] sym_t;

    localparam sym_t SYM_00 = 2'b00;
    localparam sym_t SYM_10 = 2'b10;

    typedef enum logic [1:0] {
        MODE_PRBS  = 2'd0,
        MODE_FIXED = 2'd1,
        MODE_ALT   = 2'd2,
        MODE_PRBS2 = 2'd3
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ctl_state_t;

    function automatic logic signed [17:0] sym_level(input sym_t s);
        logic signed [17:0] lvl;
        case (s)
            2'b00:   lvl = LVL_M3;
            2'b01:   lvl = LVL_M1;
            2'b11:   lvl = LVL_P1;
            default: lvl = LVL_P3;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/prbs15_2step.sv
// Combinational two-step PRBS-15 Fibonacci generator; the state register
// lives in the caller.
module prbs15_2step
    import tx_pkg::*;
(
    input  logic [LFSR_W-1:0] state,
    output logic [LFSR_W-1:0] next_state,
    output sym_t              bits
);

    logic              b1;
    logic              b2;
    logic [LFSR_W-1:0] mid;

    always_comb begin
        b1         = state[TAP_HI] ^ state[TAP_LO];
        mid        = {state[LFSR_W-2:0], b1};
        b2         = mid[TAP_HI] ^ mid[TAP_LO];
        next_state = {mid[LFSR_W-2:0], b2};
        bits       = {b1, b2};
    end

endmodule

// File: rtl/tx_sym_source.sv
// 4-ASK symbol source: PRBS-15 / fixed / alternating symbols, Gray-mapped to
// 1s17 levels and held for SPS clocks.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | after reset; phase parked at SPS-1 so first enable is a boundary
//   ST_RUN  | free-running symbol generation; left only through reset
module tx_sym_source
    import tx_pkg::*;
#(
    parameter int          SPS  = 1,
    parameter logic [14:0] SEED = 15'h0001
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [1:0]         fixed_sym,
    output logic signed [17:0] x_out,
    output logic [1:0]         sym_bits,
    output logic               sym_strobe
);

    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? 15'h0001 : SEED;
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(SPS - 1);

    ctl_state_t        state;
    logic [PH_W-1:0]   ph;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_next;
    logic              toggle;
    sym_t              prbs_bits;
    sym_t              next_sym;
    mode_t             mode_s;
    logic              boundary;
    logic              prbs_mode;

    prbs15_2step u_prbs (
        .state      (lfsr),
        .next_state (lfsr_next),
        .bits       (prbs_bits)
    );

    assign mode_s    = mode_t'(mode);
    assign boundary  = enable && ((state == ST_IDLE) || (ph == PH_LAST));
    assign prbs_mode = (mode_s == MODE_PRBS) || (mode_s == MODE_PRBS2);

    always_comb begin
        next_sym = prbs_bits;
        case (mode_s)
            MODE_FIXED: next_sym = fixed_sym;
            MODE_ALT:   next_sym = toggle ? SYM_00 : SYM_10;
            default:    next_sym = prbs_bits;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            ph         <= PH_LAST;
            lfsr       <= SEED_EFF;
            toggle     <= 1'b0;
            x_out      <= '0;
            sym_bits   <= '0;
            sym_strobe <= 1'b0;
        end else begin
            sym_strobe <= boundary;
            if (enable) begin
                state <= ST_RUN;
                ph    <= (ph == PH_LAST) ? '0 : ph + 1'b1;
            end else if (state == ST_IDLE) begin
                ph <= PH_LAST;
            end
            if (boundary) begin
                sym_bits <= next_sym;
                x_out    <= sym_level(next_sym);
                if (prbs_mode) begin
                    lfsr <= lfsr_next;
                end
                // clearing outside mode 2 makes every entry into mode 2 start at 10
                toggle <= (mode_s == MODE_ALT) ? ~toggle : 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tx_sym_source.sv
// Directed bench for tx_sym_source: three instances (SPS=1, 4, 2) share clock,
// reset and mode inputs and are exercised one at a time.
module tb_tx_sym_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic [1:0]         mode;
    logic [1:0]         fixed_sym;
    logic               en_a, en_b, en_c;
    logic signed [17:0] x_a, x_b, x_c;
    logic [1:0]         s_a, s_b, s_c;
    logic               st_a, st_b, st_c;

    int n_chk  = 0;
    int n_pass = 0;

    tx_sym_source #(.SPS(1), .SEED(15'h0001)) u_a (
        .clk(clk), .reset(reset), .enable(en_a), .mode(mode), .fixed_sym(fixed_sym),
        .x_out(x_a), .sym_bits(s_a), .sym_strobe(st_a));

    tx_sym_source #(.SPS(4), .SEED(15'h5A5A)) u_b (
        .clk(clk), .reset(reset), .enable(en_b), .mode(mode), .fixed_sym(fixed_sym),
        .x_out(x_b), .sym_bits(s_b), .sym_strobe(st_b));

    tx_sym_source #(.SPS(2), .SEED(15'h0001)) u_c (
        .clk(clk), .reset(reset), .enable(en_c), .mode(mode), .fixed_sym(fixed_sym),
        .x_out(x_c), .sym_bits(s_c), .sym_strobe(st_c));

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // returns {bit1, bit2, state after two steps}
    function automatic logic [16:0] prbs2(input logic [14:0] s);
        logic        b1, b2;
        logic [14:0] t;
        b1 = s[14] ^ s[13];
        t  = {s[13:0], b1};
        b2 = t[14] ^ t[13];
        t  = {t[13:0], b2};
        return {b1, b2, t};
    endfunction

    function automatic int lvl(input logic [1:0] b);
        case (b)
            2'b00:   return -131072;
            2'b01:   return -43690;
            2'b11:   return 43690;
            default: return 131071;
        endcase
    endfunction

    int          alt_x [6] = '{131071, 131071, -131072, -131072, 131071, 131071};
    logic [14:0] m;
    logic [16:0] r;
    logic [1:0]  e_sym;
    logic [1:0]  e2;
    int          errs;

    initial begin
        reset = 1'b0; en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        mode = 2'd0; fixed_sym = 2'b00;
        #12;
        chk("rst_x_a", x_a, 0);
        chk("rst_bits_a", s_a, 0);
        chk("rst_stb_a", st_a, 0);
        chk("rst_x_b", x_b, 0);
        chk("rst_x_c", x_c, 0);

        // enable while reset is held: nothing may happen
        en_a = 1'b1;
        tick();
        chk("rst_hold_stb_a", st_a, 0);
        reset = 1'b1;

        // SPS=1, SEED=1: full PRBS period plus wrap
        m = 15'h0001;
        errs = 0;
        for (int k = 1; k <= 32774; k++) begin
            tick();
            r = prbs2(m);
            m = r[14:0];
            e_sym = r[16:15];
            if (s_a !== e_sym || x_a != lvl(e_sym) || st_a !== 1'b1) errs++;
            if (k <= 7)
                chk($sformatf("seed_sym%0d_x", k), x_a, (k == 7) ? -43690 : -131072);
            if (k >= 32768)
                chk($sformatf("wrap_sym%0d_bits", k), s_a, (k == 32774) ? 1 : 0);
        end
        chk("prbs_stream_errs", errs, 0);

        // asynchronous reset pulse mid-clock
        #3 reset = 1'b0;
        #1;
        chk("arst_x_a", x_a, 0);
        chk("arst_stb_a", st_a, 0);
        chk("arst_bits_a", s_a, 0);
        #2 reset = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("restart_sym%0d_bits", k), s_a, (k == 7) ? 1 : 0);
            chk($sformatf("restart_sym%0d_stb", k), st_a, 1);
        end
        en_a = 1'b0;

        // SPS=4: PRBS, mid-symbol mode change, freeze, LFSR hold
        m = 15'h5A5A;
        mode = 2'd0;
        en_b = 1'b1;
        tick();                                         // edge 0
        r = prbs2(m); m = r[14:0];
        chk("b_sym1_bits", s_b, r[16:15]);
        chk("b_sym1_x", x_b, lvl(r[16:15]));
        chk("b_sym1_stb", st_b, 1);
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk($sformatf("b_e%0d_stb", e), st_b, 0);
            chk($sformatf("b_e%0d_hold", e), s_b, r[16:15]);
        end
        tick();                                         // edge 4
        r = prbs2(m); m = r[14:0];
        e2 = r[16:15];
        chk("b_sym2_bits", s_b, e2);
        chk("b_sym2_stb", st_b, 1);
        tick();                                         // edge 5, ph=1
        mode = 2'd1;
        fixed_sym = 2'b11;
        for (int e = 6; e <= 7; e++) begin
            tick();
            chk($sformatf("b_e%0d_complete", e), s_b, e2);
        end
        for (int e = 8; e <= 17; e++) begin
            tick();
            chk($sformatf("b_e%0d_fixed_x", e), x_b, 43690);
            chk($sformatf("b_e%0d_stb", e), st_b, (e % 4 == 0) ? 1 : 0);
        end
        // ph=1 here; freeze for 5 clocks
        en_b = 1'b0;
        mode = 2'd0;
        for (int e = 0; e < 5; e++) begin
            tick();
            chk($sformatf("b_frz%0d_stb", e), st_b, 0);
            chk($sformatf("b_frz%0d_x", e), x_b, 43690);
        end
        en_b = 1'b1;
        tick();
        chk("b_resume1_stb", st_b, 0);
        tick();
        chk("b_resume2_stb", st_b, 0);
        tick();
        r = prbs2(m); m = r[14:0];
        chk("b_resume3_stb", st_b, 1);
        chk("b_lfsr_held_bits", s_b, r[16:15]);
        chk("b_lfsr_held_x", x_b, lvl(r[16:15]));
        en_b = 1'b0;

        // SPS=2: alternating mode and restart on re-entry
        mode = 2'd2;
        en_c = 1'b1;
        for (int e = 0; e < 6; e++) begin
            tick();
            chk($sformatf("c_e%0d_x", e), x_c, alt_x[e]);
            chk($sformatf("c_e%0d_stb", e), st_c, (e % 2 == 0) ? 1 : 0);
        end
        mode = 2'd1;
        fixed_sym = 2'b01;
        tick();
        chk("c_e6_x", x_c, -43690);
        chk("c_e6_stb", st_c, 1);
        tick();
        chk("c_e7_x", x_c, -43690);
        chk("c_e7_stb", st_c, 0);
        mode = 2'd2;
        tick();
        chk("c_restart_x", x_c, 131071);
        chk("c_restart_stb", st_c, 1);
        tick();
        chk("c_e9_x", x_c, 131071);
        tick();
        chk("c_e10_x", x_c, -131072);
        chk("c_e10_bits", s_c, 0);
        en_c = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
